// File: rtl/dma_copy_pkg.sv
// rtl/dma_copy_pkg.sv - shared types and register offsets for the dma_copy engine
package dma_copy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_COPY = 2'd0,
    MODE_FILL = 2'd1,
    MODE_SWAP = 2'd2
  } mode_e;

  localparam logic [3:0] REG_CTRL  = 4'd0;
  localparam logic [3:0] REG_DST   = 4'd1;
  localparam logic [3:0] REG_SRC   = 4'd2;
  localparam logic [3:0] REG_COUNT = 4'd3;
  localparam logic [3:0] REG_MODE  = 4'd4;
  localparam logic [3:0] REG_DONE  = 4'd5;

endpackage

// File: rtl/dma_fifo.sv
// rtl/dma_fifo.sv - show-ahead read-data buffer between master read and write sides
module dma_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full buffer is only legal when the same edge pops.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dma_copy.sv
// rtl/dma_copy.sv - register-programmed copy / fill / byte-swap DMA engine
module dma_copy
  import dma_copy_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              slave_waitrequest,
  input  logic [3:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic              master_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_readdatavalid,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata
);

  localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int                NB        = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(NB);

  state_e              state_q, state_d;
  logic [31:0]         dst_q, dst_d, src_q, src_d, count_q, count_d;
  logic [1:0]          mode_q, mode_d;
  logic [31:0]         rd_left_q, rd_left_d, wr_left_q, wr_left_d;
  logic [31:0]         done_cnt_q, done_cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [CW-1:0]       inflight_q, inflight_d;
  logic                cmd_valid_q, cmd_valid_d, cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_data_q, cmd_data_d;

  logic                start, cfg_wr, fill_mode, swap_mode;
  logic                cmd_acc, rd_acc, wr_acc, slot_free;
  logic                active, want_wr, want_rd, rd_room, wr_issue, rd_issue;
  logic                push_ok, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [CW:0]         occ_sum;
  logic [DATA_W-1:0]   fifo_rdata, swapped, wr_word;

  assign start     = slave_write && (slave_address == REG_CTRL) && (state_q == ST_IDLE);
  assign cfg_wr    = slave_write && (state_q == ST_IDLE);
  assign fill_mode = (mode_q == MODE_FILL);
  assign swap_mode = (mode_q == MODE_SWAP);
  assign cmd_acc   = cmd_valid_q && !master_waitrequest;
  assign rd_acc    = cmd_acc && !cmd_write_q;
  assign wr_acc    = cmd_acc && cmd_write_q;
  assign slot_free = !cmd_valid_q || !master_waitrequest;

  // Stale returns after a reset release are dropped: nothing is outstanding.
  assign push_ok   = master_readdatavalid && (state_q != ST_IDLE) && (inflight_q != '0);
  assign fifo_pop  = wr_issue && !fill_mode;

  dma_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_ok),
    .push_data (master_readdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (count_q == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (fill_mode || (rd_acc && rd_left_q == '0)) state_d = ST_DRAIN;
      ST_DRAIN: if (wr_acc && wr_left_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Writes always win the single command slot so the buffer keeps draining.
  always_comb begin
    active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    occ_sum  = (CW+1)'(inflight_q) + (CW+1)'(fifo_count);
    rd_room  = occ_sum < (CW+1)'(FIFO_DEPTH);
    want_wr  = fill_mode ? (wr_left_q != '0) : !fifo_empty;
    want_rd  = !fill_mode && (rd_left_q != '0) && rd_room;
    wr_issue = active && slot_free && want_wr;
    rd_issue = active && slot_free && !want_wr && want_rd;
  end

  always_comb begin
    swapped = '0;
    for (int i = 0; i < NB; i++) swapped[8*i +: 8] = fifo_rdata[DATA_W-8-8*i +: 8];
    if (fill_mode)      wr_word = DATA_W'(src_q);
    else if (swap_mode) wr_word = swapped;
    else                wr_word = fifo_rdata;
  end

  always_comb begin
    dst_d       = dst_q;
    src_d       = src_q;
    count_d     = count_q;
    mode_d      = mode_q;
    rd_left_d   = rd_left_q;
    wr_left_d   = wr_left_q;
    done_cnt_d  = done_cnt_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    inflight_d  = inflight_q;
    cmd_valid_d = cmd_valid_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;

    if (cfg_wr) begin
      case (slave_address)
        REG_DST:   dst_d   = slave_writedata;
        REG_SRC:   src_d   = slave_writedata;
        REG_COUNT: count_d = slave_writedata;
        REG_MODE:  mode_d  = slave_writedata[1:0];
        default:   ;
      endcase
    end

    if (start) begin
      rd_addr_d  = ADDR_W'(src_q);
      wr_addr_d  = ADDR_W'(dst_q);
      rd_left_d  = fill_mode ? '0 : count_q;
      wr_left_d  = count_q;
      done_cnt_d = '0;
      inflight_d = '0;
    end else begin
      if (rd_issue) begin
        rd_left_d = rd_left_q - 32'd1;
        rd_addr_d = rd_addr_q + ADDR_STEP;
      end
      if (wr_issue) begin
        wr_left_d = wr_left_q - 32'd1;
        wr_addr_d = wr_addr_q + ADDR_STEP;
      end
      if (wr_acc) done_cnt_d = done_cnt_q + 32'd1;
      case ({rd_issue, push_ok})
        2'b10:   inflight_d = inflight_q + CW'(1);
        2'b01:   inflight_d = inflight_q - CW'(1);
        default: inflight_d = inflight_q;
      endcase
    end

    // The command register holds everything stable until it is accepted.
    if (slot_free) begin
      cmd_valid_d = wr_issue || rd_issue;
      cmd_write_d = wr_issue;
      if (wr_issue) begin
        cmd_addr_d = wr_addr_q;
        cmd_data_d = wr_word;
      end else if (rd_issue) begin
        cmd_addr_d = rd_addr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q       <= '0;
      src_q       <= '0;
      count_q     <= '0;
      mode_q      <= '0;
      rd_left_q   <= '0;
      wr_left_q   <= '0;
      done_cnt_q  <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      inflight_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
    end else begin
      dst_q       <= dst_d;
      src_q       <= src_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      rd_left_q   <= rd_left_d;
      wr_left_q   <= wr_left_d;
      done_cnt_q  <= done_cnt_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      inflight_q  <= inflight_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

  assign master_read       = cmd_valid_q && !cmd_write_q;
  assign master_write      = cmd_valid_q && cmd_write_q;
  assign master_address    = cmd_addr_q;
  assign master_writedata  = cmd_data_q;
  assign slave_waitrequest = slave_read && (slave_address == REG_CTRL) && (state_q != ST_IDLE);

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        REG_DST:   slave_readdata = dst_q;
        REG_SRC:   slave_readdata = src_q;
        REG_COUNT: slave_readdata = count_q;
        REG_MODE:  slave_readdata = {30'd0, mode_q};
        REG_DONE:  slave_readdata = done_cnt_q;
        default:   slave_readdata = '0;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = fifo_full;

endmodule

// File: tb/tb_dma_copy.sv
// tb/tb_dma_copy.sv - scoreboard bench for dma_copy with a latency/backpressure SDRAM model
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = '0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  always #5 clk = ~clk;

  dma_copy dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int due; logic [31:0] d; } rd_t;

  wr_t         exp_q[$];
  rd_t         pipe[$];
  logic [31:0] mem [1024];
  int          n_checks = 0, n_pass = 0;
  int          cyc = 0, lat = 1;
  bit          bp_en = 1'b0;
  int          inflight = 0, max_inflight = 0, rd_high = 0, wr_high = 0, wr_accepts = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] src_word(input int i);
    return {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
  endfunction

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // SDRAM input driver: random waitrequest and fixed-latency read returns.
  initial begin
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      master_waitrequest = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (pipe.size() != 0 && pipe[0].due <= cyc + 1) begin
        master_readdatavalid = 1'b1;
        master_readdata      = pipe[0].d;
        void'(pipe.pop_front());
      end else begin
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
      end
    end
  end

  // SDRAM storage and traffic observation, sampled mid-cycle.
  initial begin
    rd_t r;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) mem[i] = src_word(i);
    mem[64] = 32'h1122_3344;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (master_read)  rd_high++;
        if (master_write) wr_high++;
        if (master_read && !master_waitrequest) begin
          r.due = cyc + 1 + lat;
          r.d   = mem[master_address[11:2]];
          pipe.push_back(r);
          inflight++;
        end
        if (master_readdatavalid && inflight > 0) inflight--;
        if (inflight > max_inflight) max_inflight = inflight;
        if (master_write && !master_waitrequest) mem[master_address[11:2]] = master_writedata;
      end else begin
        inflight = 0;
      end
    end
  end

  // Write scoreboard: every accepted master write is matched against exp_q.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && master_write && !master_waitrequest) begin
        wr_accepts++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   master_address, master_writedata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(master_address), 64'(e.addr));
          chk("wr_data", 64'(master_writedata), 64'(e.data));
        end
      end
    end
  end

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    slave_address   = a;
    slave_writedata = d;
    slave_write     = 1'b1;
    @(posedge clk);
    #1;
    slave_write = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, input int bound, output logic [31:0] d, output int waits);
    slave_address = a;
    slave_read    = 1'b1;
    waits = 0;
    d = '0;
    forever begin
      @(negedge clk);
      if (!slave_waitrequest) begin
        d = slave_readdata;
        break;
      end
      waits++;
      if (waits > bound) begin
        n_checks++;
        $display("FAIL read_timeout: reg %0d still waiting after %0d cycles, limit %0d", a, waits, bound);
        break;
      end
    end
    @(posedge clk);
    #1;
    slave_read = 1'b0;
  endtask

  task automatic setup(input logic [31:0] dst, input logic [31:0] src, input logic [31:0] cnt,
                       input logic [31:0] mode);
    reg_write(4'd1, dst);
    reg_write(4'd2, src);
    reg_write(4'd3, cnt);
    reg_write(4'd4, mode);
  endtask

  task automatic wait_idle(output logic [31:0] st);
    int w;
    reg_read(4'd0, 5000, st, w);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          w, r0, w0, base;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst_master_read", 64'(master_read), 64'd0);
    chk("rst_master_write", 64'(master_write), 64'd0);
    chk("rst_master_address", 64'(master_address), 64'd0);
    chk("rst_slave_waitrequest", 64'(slave_waitrequest), 64'd0);
    reg_read(4'd5, 10, d, w);
    chk("rst_reg5", 64'(d), 64'd0);

    // Plain copy of four words.
    lat = 1;
    setup(32'h40, 32'h0, 32'd4, 32'd0);
    expect_wr(32'h40, 32'h0001_0203);
    expect_wr(32'h44, 32'h0405_0607);
    expect_wr(32'h48, 32'h0809_0A0B);
    expect_wr(32'h4C, 32'h0C0D_0E0F);
    reg_write(4'd0, 32'd1);
    wait_idle(d);
    chk("copy_status", 64'(d), 64'd0);
    reg_read(4'd5, 10, d, w);
    chk("copy_reg5", 64'(d), 64'd4);
    chk("copy_all_written", 64'(exp_q.size()), 64'd0);

    // Fill: no reads at all.
    r0 = rd_high;
    setup(32'h80, 32'hDEAD_BEEF, 32'd3, 32'd1);
    expect_wr(32'h80, 32'hDEAD_BEEF);
    expect_wr(32'h84, 32'hDEAD_BEEF);
    expect_wr(32'h88, 32'hDEAD_BEEF);
    reg_write(4'd0, 32'd1);
    wait_idle(d);
    chk("fill_no_reads", 64'(rd_high - r0), 64'd0);
    reg_read(4'd5, 10, d, w);
    chk("fill_reg5", 64'(d), 64'd3);
    chk("fill_all_written", 64'(exp_q.size()), 64'd0);

    // Byte swap.
    setup(32'h200, 32'h100, 32'd1, 32'd2);
    expect_wr(32'h200, 32'h4433_2211);
    reg_write(4'd0, 32'd1);
    wait_idle(d);
    chk("swap_all_written", 64'(exp_q.size()), 64'd0);

    // Backpressure with long read latency.
    bp_en = 1'b1;
    lat = 5;
    setup(32'h300, 32'h0, 32'd16, 32'd0);
    for (int i = 0; i < 16; i++) expect_wr(32'h300 + 32'(4*i), src_word(i));
    reg_write(4'd0, 32'd1);
    wait_idle(d);
    bp_en = 1'b0;
    chk("bp_all_written", 64'(exp_q.size()), 64'd0);
    chk("bp_inflight_le_8", 64'(max_inflight <= 8), 64'd1);
    reg_read(4'd5, 10, d, w);
    chk("bp_reg5", 64'(d), 64'd16);

    // Zero count: straight through DONE with no master traffic.
    lat = 1;
    r0 = rd_high;
    w0 = wr_high;
    setup(32'h500, 32'h0, 32'd0, 32'd0);
    reg_write(4'd0, 32'd1);
    reg_read(4'd0, 10, d, w);
    chk("zero_status_within_3", 64'(w <= 3), 64'd1);
    chk("zero_no_reads", 64'(rd_high - r0), 64'd0);
    chk("zero_no_writes", 64'(wr_high - w0), 64'd0);
    reg_read(4'd5, 10, d, w);
    chk("zero_reg5", 64'(d), 64'd0);

    // Register writes and a second start while busy are dropped.
    setup(32'h400, 32'h0, 32'd4, 32'd0);
    for (int i = 0; i < 4; i++) expect_wr(32'h400 + 32'(4*i), src_word(i));
    bp_en = 1'b1;
    reg_write(4'd0, 32'd1);
    reg_write(4'd1, 32'h500);
    reg_write(4'd3, 32'd99);
    reg_write(4'd0, 32'd1);
    wait_idle(d);
    bp_en = 1'b0;
    reg_read(4'd1, 10, d, w);
    chk("busy_dst_kept", 64'(d), 64'h400);
    reg_read(4'd3, 10, d, w);
    chk("busy_count_kept", 64'(d), 64'd4);
    reg_read(4'd5, 10, d, w);
    chk("busy_reg5", 64'(d), 64'd4);
    chk("busy_all_written", 64'(exp_q.size()), 64'd0);

    // Reset mid-copy after two writes.
    lat = 3;
    setup(32'h600, 32'h0, 32'd8, 32'd0);
    for (int i = 0; i < 8; i++) expect_wr(32'h600 + 32'(4*i), src_word(i));
    base = wr_accepts;
    reg_write(4'd0, 32'd1);
    w = 0;
    while (wr_accepts < base + 2 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("rst_two_writes_seen", 64'(wr_accepts >= base + 2), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_master_read", 64'(master_read), 64'd0);
    chk("midrst_master_write", 64'(master_write), 64'd0);
    chk("midrst_master_address", 64'(master_address), 64'd0);
    chk("midrst_master_writedata", 64'(master_writedata), 64'd0);
    chk("midrst_slave_waitrequest", 64'(slave_waitrequest), 64'd0);
    chk("midrst_slave_readdata", 64'(slave_readdata), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    reg_read(4'd5, 10, d, w);
    chk("postrst_reg5", 64'(d), 64'd0);
    reg_read(4'd0, 10, d, w);
    chk("postrst_idle", 64'(w), 64'd0);

    setup(32'h700, 32'h0, 32'd2, 32'd0);
    expect_wr(32'h700, 32'h0001_0203);
    expect_wr(32'h704, 32'h0405_0607);
    reg_write(4'd0, 32'd1);
    wait_idle(d);
    reg_read(4'd5, 10, d, w);
    chk("postrst_copy_reg5", 64'(d), 64'd2);
    chk("postrst_all_written", 64'(exp_q.size()), 64'd0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_copy.md
DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 Parameter DATA_W, default 32, master/slave data width in bits; SHALL be a power of two, at least 32.
REQ-002 Parameter ADDR_W, default 32, master byte-address width.
REQ-003 Parameter FIFO_DEPTH, default 8, read-data buffer depth and maximum in-flight reads; SHALL be a power of two, at least 2.
REQ-004 Port clk, input, 1, single clock; all logic SHALL be rising-edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Slave ports, CPU-facing: slave_waitrequest out 1; slave_address in 4; slave_read in 1; slave_readdata out 32; slave_write in 1; slave_writedata in 32.
REQ-007 Master ports, SDRAM-facing: master_waitrequest in 1; master_address out ADDR_W; master_read out 1; master_readdata in DATA_W; master_readdatavalid in 1; master_write out 1; master_writedata out DATA_W.

Function
REQ-008 Slave register map SHALL be:
- 0: write = start; read = status.
- 1: destination byte address.
- 2: source byte address, or the fill pattern in fill mode.
- 3: word count.
- 4: mode; 0 = copy, 1 = fill, 2 = copy with byte-swap.
- 5: words completed, read-only.
REQ-009 Writes to registers 1-4 SHALL be accepted only in IDLE; while busy they SHALL be dropped.
REQ-010 A write to register 0 in IDLE SHALL start a transfer; a write to register 0 while busy SHALL be ignored.
REQ-011 A read of register 0 SHALL hold slave_waitrequest high until the FSM returns to IDLE, then return 0 with waitrequest low.
REQ-012 Reads of all other registers SHALL complete with zero wait states.
REQ-013 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start.
- RUN -> DRAIN when the last read command is accepted.
- DRAIN -> DONE when the last write is accepted.
- DONE -> IDLE after exactly 1 cycle.
REQ-014 Fill mode SHALL skip reads: RUN -> DRAIN immediately; the fill pattern (zero-extended to DATA_W) is written count times.
REQ-015 Start with count 0 SHALL go IDLE -> DONE -> IDLE with no master traffic.
REQ-016 Read and write addresses SHALL advance by DATA_W/8 per accepted command and wrap modulo 2^ADDR_W.
REQ-017 A master command SHALL be held stable while master_waitrequest is high and is counted only on a cycle where waitrequest is low.
REQ-018 At most one master command SHALL issue per cycle; a write issues when the FIFO is non-empty, otherwise a read issues when one is permitted.
REQ-019 A read SHALL be permitted only while reads remain and in-flight reads plus FIFO occupancy < FIFO_DEPTH, so FIFO overflow cannot occur.
REQ-020 master_readdatavalid data SHALL be pushed into the FIFO on the same edge; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-021 Copy-with-byte-swap mode SHALL reverse byte order within each DATA_W word on the write side.
REQ-022 Register 5 SHALL count accepted writes and clear on start.
REQ-023 Read-to-write latency SHALL be 1 cycle minimum: data valid at edge N may be written at edge N+1.

Reset
REQ-024 On rst_n low SHALL apply immediately and asynchronously, at any point including mid-transfer:
- FSM -> IDLE.
- FIFO emptied; all counters and registers cleared.
- master_read, master_write, slave_waitrequest = 0.
- master_address, master_writedata, slave_readdata = 0.
REQ-025 Readdatavalid pulses arriving after a reset release SHALL be discarded while in IDLE.

Structure
REQ-026 Package dma_copy_pkg SHALL hold the state enum, the mode enum and the register-offset constants.
REQ-027 The buffer SHALL be the sub-module dma_fifo, parameterised on width and depth, exposing full, empty and a count output.

Verification
REQ-028 The bench SHALL cover the following scenarios:
- Copy: src=0x0, dst=0x40, count=4, SDRAM[0..15]=0..15, no waitrequest -> dst words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F; register 5 = 4.
- Fill: pattern=0xDEADBEEF, dst=0x80, count=3 -> three identical writes at 0x80/0x84/0x88; zero master_read pulses.
- Backpressure: copy with count=16, random master_waitrequest 50%, readdatavalid latency 5 -> data correct; in-flight reads never exceed 8.
- Byte-swap: src word 0x11223344 -> written word 0x44332211.
- Boundary: count=0 -> status read completes within 3 cycles with no master traffic; register writes and start while busy are ignored.
- Reset: rst_n low mid-copy after 2 writes -> all outputs 0 in the same cycle; a new copy with count=2 then completes correctly.
